// File: rtl/event_counter_if.sv
// rtl/event_counter_if.sv - control and status bundle for event_counter
interface event_counter_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             stop;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic             oneshot;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             done;
  logic             wrap;

  modport master (
    output start, stop, clear, load, load_val, dir, oneshot, target,
    input  count, running, done, wrap
  );

  modport slave (
    input  start, stop, clear, load, load_val, dir, oneshot, target,
    output count, running, done, wrap
  );
endinterface

// File: rtl/event_counter.sv
// rtl/event_counter.sv - up/down event counter with one-shot FSM, wrap or saturate
module event_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  event_counter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  state_t           state;
  logic             start_q, stop_q, clear_q, load_q;
  logic [WIDTH-1:0] load_val_q;
  logic [WIDTH-1:0] count_q;
  logic             running_q, done_q, wrap_q;

  logic [WIDTH-1:0] limit, step_val, next_count;
  logic             at_limit, next_wrap;

  // In saturate mode the wrap pulse marks arrival at the limit, not the hold.
  always_comb begin
    limit    = bus.dir ? ZERO : ALL_ONES;
    at_limit = (count_q == limit);
    step_val = bus.dir ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
    if (SATURATE) begin
      next_count = at_limit ? count_q : step_val;
      next_wrap  = !at_limit && (step_val == limit);
    end else begin
      next_count = step_val;
      next_wrap  = at_limit;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      clear_q    <= 1'b0;
      load_q     <= 1'b0;
      load_val_q <= ZERO;
      count_q    <= ZERO;
      state      <= IDLE;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      start_q    <= bus.start;
      stop_q     <= bus.stop;
      clear_q    <= bus.clear;
      load_q     <= bus.load;
      load_val_q <= bus.load_val;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;

      if (clear_q) begin
        count_q   <= ZERO;
        state     <= IDLE;
        running_q <= 1'b0;
      end else begin
        // Load overrides count only; DONE still retires after one cycle.
        unique case (state)
          IDLE: begin
            if (!load_q && !stop_q && start_q) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            if (load_q) begin
              count_q <= load_val_q;
            end else if (stop_q) begin
              state     <= IDLE;
              running_q <= 1'b0;
            end else if (bus.oneshot && count_q == bus.target) begin
              state     <= DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              count_q <= next_count;
              wrap_q  <= next_wrap;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state     <= IDLE;
            running_q <= 1'b0;
          end
        endcase
        if (load_q) count_q <= load_val_q;
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_event_counter.sv
// tb/tb_event_counter.sv - scoreboard bench for event_counter, wrap and saturate builds
module tb_event_counter;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, stop, clear, load, dir, oneshot;
  logic [7:0] load_val, target;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct {
    int         cyc;
    int         dut;
    logic [7:0] count;
    logic       running;
    logic       done;
    logic       wrap;
    string      name;
  } exp_t;

  exp_t sb[$];

  event_counter_if #(.WIDTH(8)) if0 ();
  event_counter_if #(.WIDTH(8)) if1 ();

  assign if0.start = start;   assign if1.start = start;
  assign if0.stop = stop;     assign if1.stop = stop;
  assign if0.clear = clear;   assign if1.clear = clear;
  assign if0.load = load;     assign if1.load = load;
  assign if0.load_val = load_val; assign if1.load_val = load_val;
  assign if0.dir = dir;       assign if1.dir = dir;
  assign if0.oneshot = oneshot; assign if1.oneshot = oneshot;
  assign if0.target = target; assign if1.target = target;

  event_counter #(.WIDTH(8), .SATURATE(1'b0)) u_wrap (.clk(clk), .reset_n(reset_n), .bus(if0));
  event_counter #(.WIDTH(8), .SATURATE(1'b1)) u_sat  (.clk(clk), .reset_n(reset_n), .bus(if1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic exp1(input int off, input string nm, input int d, input logic [7:0] c,
                      input logic r, input logic dn, input logic w);
    exp_t e;
    e.cyc = cyc + off; e.dut = d; e.count = c;
    e.running = r; e.done = dn; e.wrap = w; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic expb(input int off, input string nm, input logic [7:0] c,
                      input logic r, input logic dn, input logic w);
    exp1(off, nm, 0, c, r, dn, w);
    exp1(off, nm, 1, c, r, dn, w);
  endtask

  // Monitor: compares every expectation scheduled for the current cycle.
  initial begin
    exp_t       e;
    logic [7:0] a_count;
    logic       a_run, a_done, a_wrap;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (e.dut == 0) begin
          a_count = if0.count; a_run = if0.running; a_done = if0.done; a_wrap = if0.wrap;
        end else begin
          a_count = if1.count; a_run = if1.running; a_done = if1.done; a_wrap = if1.wrap;
        end
        if (e.cyc < cyc) begin
          n_fail++;
          $display("FAIL %s dut%0d: expectation for cycle %0d was not sampled (now %0d)",
                   e.name, e.dut, e.cyc, cyc);
        end else if (a_count !== e.count || a_run !== e.running ||
                     a_done !== e.done || a_wrap !== e.wrap) begin
          n_fail++;
          $display("FAIL %s dut%0d cyc%0d: got count=%h run=%b done=%b wrap=%b, expected count=%h run=%b done=%b wrap=%b",
                   e.name, e.dut, cyc, a_count, a_run, a_done, a_wrap,
                   e.count, e.running, e.done, e.wrap);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    dir = 1'b0; oneshot = 1'b0; load_val = 8'h00; target = 8'h00;
    step(); step();
    expb(0, "reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();

    // one-shot up to 5
    oneshot = 1'b1; target = 8'h05; dir = 1'b0; start = 1'b1;
    expb(2, "os_enter", 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) expb(2 + k, "os_count", 8'(k), 1'b1, 1'b0, 1'b0);
    expb(8, "os_done", 8'h05, 1'b0, 1'b1, 1'b0);
    expb(9, "os_idle", 8'h05, 1'b0, 1'b0, 1'b0);
    expb(10, "os_hold", 8'h05, 1'b0, 1'b0, 1'b0);
    step(); start = 1'b0;
    repeat (9) step();

    // load 0xFE, free-run up through the top
    oneshot = 1'b0; dir = 1'b0; load = 1'b1; load_val = 8'hFE;
    expb(2, "up_load", 8'hFE, 1'b0, 1'b0, 1'b0);
    expb(3, "up_run", 8'hFE, 1'b1, 1'b0, 1'b0);
    exp1(4, "wrap_ff", 0, 8'hFF, 1'b1, 1'b0, 1'b0);
    exp1(4, "sat_ff", 1, 8'hFF, 1'b1, 1'b0, 1'b1);
    exp1(5, "wrap_00", 0, 8'h00, 1'b1, 1'b0, 1'b1);
    exp1(5, "sat_hold", 1, 8'hFF, 1'b1, 1'b0, 1'b0);
    exp1(6, "wrap_01", 0, 8'h01, 1'b1, 1'b0, 1'b0);
    exp1(6, "sat_hold", 1, 8'hFF, 1'b1, 1'b0, 1'b0);
    exp1(7, "wrap_02", 0, 8'h02, 1'b1, 1'b0, 1'b0);
    exp1(7, "sat_hold", 1, 8'hFF, 1'b1, 1'b0, 1'b0);
    exp1(8, "up_stop", 0, 8'h02, 1'b0, 1'b0, 1'b0);
    exp1(8, "up_stop", 1, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(); load = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    repeat (4) step(); stop = 1'b1;
    step(); stop = 1'b0;
    step();

    // load 0x02, count down through zero, then clear/load/stop together
    dir = 1'b1; load = 1'b1; load_val = 8'h02;
    expb(2, "dn_load", 8'h02, 1'b0, 1'b0, 1'b0);
    expb(3, "dn_run", 8'h02, 1'b1, 1'b0, 1'b0);
    expb(4, "dn_01", 8'h01, 1'b1, 1'b0, 1'b0);
    exp1(5, "dn_00", 0, 8'h00, 1'b1, 1'b0, 1'b0);
    exp1(5, "sat_00", 1, 8'h00, 1'b1, 1'b0, 1'b1);
    exp1(6, "wrap_dn_ff", 0, 8'hFF, 1'b1, 1'b0, 1'b1);
    exp1(6, "sat_hold0", 1, 8'h00, 1'b1, 1'b0, 1'b0);
    exp1(7, "wrap_dn_fe", 0, 8'hFE, 1'b1, 1'b0, 1'b0);
    exp1(7, "sat_hold0", 1, 8'h00, 1'b1, 1'b0, 1'b0);
    expb(8, "prio_clear", 8'h00, 1'b0, 1'b0, 1'b0);
    expb(9, "prio_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    step(); load = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    repeat (4) step(); clear = 1'b1; load = 1'b1; load_val = 8'h33; stop = 1'b1;
    step(); clear = 1'b0; load = 1'b0; stop = 1'b0;
    repeat (2) step();

    // stop lands on 0x10
    dir = 1'b0; oneshot = 1'b0; load = 1'b1; load_val = 8'h0E;
    expb(2, "stop_load", 8'h0E, 1'b0, 1'b0, 1'b0);
    expb(3, "stop_run", 8'h0E, 1'b1, 1'b0, 1'b0);
    expb(4, "stop_0f", 8'h0F, 1'b1, 1'b0, 1'b0);
    expb(5, "stop_10", 8'h10, 1'b1, 1'b0, 1'b0);
    expb(6, "stop_idle", 8'h10, 1'b0, 1'b0, 1'b0);
    expb(7, "stop_hold", 8'h10, 1'b0, 1'b0, 1'b0);
    step(); load = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    repeat (2) step(); stop = 1'b1;
    step(); stop = 1'b0;
    repeat (2) step();

    // one-shot entered with count already at target
    oneshot = 1'b1; target = 8'h10; start = 1'b1;
    expb(2, "os_eq_run", 8'h10, 1'b1, 1'b0, 1'b0);
    expb(3, "os_eq_done", 8'h10, 1'b0, 1'b1, 1'b0);
    expb(4, "os_eq_idle", 8'h10, 1'b0, 1'b0, 1'b0);
    step(); start = 1'b0;
    repeat (3) step();

    // asynchronous reset mid-count
    oneshot = 1'b0; start = 1'b1;
    expb(2, "rst_pre_run", 8'h10, 1'b1, 1'b0, 1'b0);
    expb(3, "rst_pre_11", 8'h11, 1'b1, 1'b0, 1'b0);
    step(); start = 1'b0;
    repeat (3) step();
    reset_n = 1'b0;
    expb(0, "rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    reset_n = 1'b1;
    expb(1, "rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    expb(2, "rst_stay", 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) step();

    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/event_counter.md
EVENT_COUNTER -- requirements
Module: event_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (2..32).
REQ-002 SHALL have parameter SATURATE, default 0; 1 = hold at limit, 0 = wrap around.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to begin counting (level).
REQ-006 SHALL have port stop, input, 1, request to abort counting.
REQ-007 SHALL have port clear, input, 1, synchronous clear of count and FSM.
REQ-008 SHALL have port load, input, 1, load count from load_val.
REQ-009 SHALL have port load_val, input, WIDTH, value to load.
REQ-010 SHALL have port dir, input, 1, 0 = count up, 1 = count down.
REQ-011 SHALL have port oneshot, input, 1, 1 = stop at target, 0 = free-run.
REQ-012 SHALL have port target, input, WIDTH, terminal value for one-shot mode.
REQ-013 SHALL have port count, output, WIDTH, current count (registered).
REQ-014 SHALL have port running, output, 1, high while FSM is in RUN.
REQ-015 SHALL have port done, output, 1, one-cycle pulse on one-shot completion.
REQ-016 SHALL have port wrap, output, 1, one-cycle pulse on wrap or saturation hit.

Function
REQ-017 start, stop, clear, load and load_val SHALL each be registered once before use; all control acts one cycle after sampling.
REQ-018 dir, oneshot and target SHALL be used unregistered.
REQ-019 FSM SHALL have states IDLE, RUN and DONE.
REQ-020 In IDLE, registered start = 1 SHALL move the FSM to RUN; count holds.
REQ-021 Latency: start high at edge N -> running = 1 after edge N+1 -> first count change at edge N+2.
REQ-022 In RUN, count SHALL change by +1 (dir = 0) or -1 (dir = 1) on every edge.
REQ-023 In RUN with oneshot = 1 and count == target, FSM SHALL go to DONE and count SHALL hold at target.
REQ-024 done SHALL be high exactly while the FSM is in DONE; DONE SHALL last one cycle, then return to IDLE.
REQ-025 In RUN with oneshot = 0, reaching target SHALL have no effect.
REQ-026 With SATURATE = 0, up from all-ones SHALL give 0 and down from 0 SHALL give all-ones; wrap pulses one cycle, aligned with the new count.
REQ-027 With SATURATE = 1, count SHALL hold at all-ones (up) or 0 (down); wrap pulses only on the first cycle the limit is reached.
REQ-028 Registered stop in RUN SHALL return the FSM to IDLE with count held; done SHALL NOT pulse.
REQ-029 Registered load SHALL set count = registered load_val in any state; FSM state is unchanged, and load replaces that cycle's increment/decrement.
REQ-030 Registered clear SHALL set count = 0, FSM = IDLE, and done = wrap = 0.
REQ-031 Priority within one cycle SHALL be: clear > load > stop > start/count.
REQ-032 Registered start while in RUN or DONE SHALL be ignored.
REQ-033 If count == target when RUN is entered in one-shot mode, the FSM SHALL go to DONE on the next edge without counting.

Reset
REQ-034 On reset_n low, all of the following SHALL clear to 0 immediately and asynchronously: count, all input registers, running, done and wrap; FSM = IDLE.
REQ-035 Reset asserted mid-RUN SHALL abort with no done or wrap pulse; after release the FSM SHALL stay in IDLE until a new start.

Verification
REQ-036 Reset check: assert reset_n = 0 mid-count -> count = 0x00, running = 0, done = 0 and wrap = 0 in the same cycle.
REQ-037 One-shot up: WIDTH = 8, oneshot = 1, target = 5, start pulse -> count 1..5, done high one cycle at count = 5, then IDLE with count = 5.
REQ-038 Wrap: SATURATE = 0, load 0xFE, free-run up -> count 0xFF, 0x00, 0x01; wrap high only with 0x00.
REQ-039 Saturate: SATURATE = 1, load 0x02, dir = 1 -> count 0x01, 0x00, 0x00 ...; wrap pulses once.
REQ-040 Priority: clear, load (0x33) and stop all high in one cycle during RUN -> count = 0x00, FSM IDLE, done = 0.
REQ-041 Stop: stop pulse during RUN at count 0x10 -> running low one cycle later, count holds 0x10, no done pulse.
